// File: rtl/dfe_out_fifo.sv
// dfe_out_fifo: APB-readable FIFO buffering signed DFE output samples.
//
// Ports
//   PCLK, PRESETn         clock (rising edge) / async active-low reset
//   PSEL/PENABLE/PWRITE   APB controls, zero-wait-state accesses
//   PADDR, PWDATA         word register index / write data
//   PRDATA                read data (combinational during the access phase)
//   dfe_data_in           signed sample from the DFE
//   dfe_valid_in          one-cycle strobe marking a new sample
//   irq_out               registered level interrupt
//
// Registers: 0x0 CTRL (EN, FLUSH, THRESH), 0x1 STATUS, 0x2 DATA (pop on read),
//            0x3 OVFCNT (only with DFE_FIFO_OVF_CNT_EN defined, else reads 0).
//
// Optional feature macro: DFE_FIFO_OVF_CNT_EN (saturating dropped-sample counter).
module dfe_out_fifo #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ABP_ADDR_WIDTH = 4,
  parameter int unsigned ABP_DATA_WIDTH = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ABP_ADDR_WIDTH-1:0] PADDR,
  input  logic [ABP_DATA_WIDTH-1:0] PWDATA,
  output logic [ABP_DATA_WIDTH-1:0] PRDATA,
  input  logic [DATA_WIDTH-1:0]     dfe_data_in,
  input  logic                      dfe_valid_in,
  output logic                      irq_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ABP_ADDR_WIDTH-1:0] ADDR_CTRL   = ABP_ADDR_WIDTH'(0);
  localparam logic [ABP_ADDR_WIDTH-1:0] ADDR_STATUS = ABP_ADDR_WIDTH'(1);
  localparam logic [ABP_ADDR_WIDTH-1:0] ADDR_DATA   = ABP_ADDR_WIDTH'(2);
  localparam logic [ABP_ADDR_WIDTH-1:0] ADDR_OVFCNT = ABP_ADDR_WIDTH'(3);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  ctrl_en;
  logic [3:0]            ctrl_thresh;
  logic                  ovf, unf;

  logic access, wr_acc, rd_acc;
  logic flush, pop_req, push_req;
  logic empty, full;
  logic pop_ok, push_ok, ovf_set, unf_set;
  logic thresh_hit;
  logic [ABP_DATA_WIDTH-1:0] ovf_cnt_rd;

  // Only selected PWDATA bits are decoded; fold the rest into a sink.
  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA;

  // APB decode and FIFO handshake qualification
  assign access   = PSEL & PENABLE;
  assign wr_acc   = access & PWRITE;
  assign rd_acc   = access & ~PWRITE;
  assign flush    = wr_acc & (PADDR == ADDR_CTRL) & PWDATA[1];
  assign pop_req  = rd_acc & (PADDR == ADDR_DATA);
  assign push_req = ctrl_en & dfe_valid_in;
  assign empty    = (count == CNT_W'(0));
  assign full     = (count == CNT_W'(DEPTH));

  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  // A flush overrides everything, including the sticky-flag events.
  assign pop_ok  = ~flush & pop_req & ~empty;
  assign unf_set = ~flush & pop_req & empty;
  assign push_ok = ~flush & push_req & (~full | pop_ok);
  assign ovf_set = ~flush & push_req & full & ~pop_ok;

  assign thresh_hit = ctrl_en && (ctrl_thresh != 4'd0) &&
                      (32'(count) >= 32'(ctrl_thresh));

  // Sample storage (no reset needed; validity is tracked by count)
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= dfe_data_in;
  end

  // Control register, pointers, count, sticky flags and interrupt
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_en     <= 1'b0;
      ctrl_thresh <= 4'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      irq_out     <= 1'b0;
    end else begin
      if (wr_acc && (PADDR == ADDR_CTRL)) begin
        ctrl_en     <= PWDATA[0];
        ctrl_thresh <= PWDATA[7:4];
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      // A new event wins over a same-cycle write-1-to-clear.
      if (ovf_set) ovf <= 1'b1;
      else if (wr_acc && (PADDR == ADDR_STATUS) && PWDATA[18]) ovf <= 1'b0;
      if (unf_set) unf <= 1'b1;
      else if (wr_acc && (PADDR == ADDR_STATUS) && PWDATA[19]) unf <= 1'b0;

      irq_out <= thresh_hit | ovf;
    end
  end

`ifdef DFE_FIFO_OVF_CNT_EN
  // Saturating count of dropped samples; any write to OVFCNT clears it.
  logic [15:0] ovf_cnt;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ovf_cnt <= 16'd0;
    end else if (wr_acc && (PADDR == ADDR_OVFCNT)) begin
      ovf_cnt <= 16'd0;
    end else if (ovf_set && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
  assign ovf_cnt_rd = ABP_DATA_WIDTH'(ovf_cnt);
`else
  assign ovf_cnt_rd = '0;
`endif

  // Read mux: zero outside a read access phase and for unmapped addresses
  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      case (PADDR)
        ADDR_CTRL: begin
          PRDATA[0]   = ctrl_en;
          PRDATA[7:4] = ctrl_thresh;
        end
        ADDR_STATUS: begin
          PRDATA[PTR_W:0] = count;
          PRDATA[16]      = empty;
          PRDATA[17]      = full;
          PRDATA[18]      = ovf;
          PRDATA[19]      = unf;
        end
        ADDR_DATA: begin
          if (!empty) PRDATA = ABP_DATA_WIDTH'($signed(mem[rd_ptr]));
        end
        ADDR_OVFCNT: PRDATA = ovf_cnt_rd;
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dfe_out_fifo.sv
// tb_dfe_out_fifo: directed self-checking bench for dfe_out_fifo (default
// parameters: 16-bit samples, 16 entries, 4-bit address, 32-bit data).
// All inputs change 1 time unit after a rising edge.
module tb_dfe_out_fifo;

  logic        CLK_tb;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic [15:0] dfe_data_in;
  logic        dfe_valid_in;
  logic        irq_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  dfe_out_fifo dut (
    .PCLK         (CLK_tb),
    .PRESETn      (PRESETn),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .dfe_data_in  (dfe_data_in),
    .dfe_valid_in (dfe_valid_in),
    .irq_out      (irq_out)
  );

  initial CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_tb); #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    #1 d = PRDATA;
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    dfe_data_in = v; dfe_valid_in = 1'b1;
    step();
    dfe_valid_in = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; dfe_data_in = '0; dfe_valid_in = 1'b0;
    repeat (3) step();
    check("rst_irq", 32'(irq_out), 32'd0);
    check("rst_prdata_idle", PRDATA, 32'd0);
    PRESETn = 1'b1;
    step();

    // Reset state
    apb_read(4'h1, rd); check("status_after_reset", rd, 32'h0001_0000);
    check("irq_after_reset", 32'(irq_out), 32'd0);

    // Threshold interrupt and sign extension
    apb_write(4'h0, 32'h31);
    push(16'h8001); push(16'h7FFF); push(16'h0005);
    check("irq_same_cycle_as_3rd", 32'(irq_out), 32'd0);
    step();
    check("irq_after_3rd", 32'(irq_out), 32'd1);
    apb_read(4'h0, rd); check("ctrl_readback", rd, 32'h31);
    apb_read(4'h2, rd); check("data0", rd, 32'hFFFF_8001);
    apb_read(4'h2, rd); check("data1", rd, 32'h0000_7FFF);
    apb_read(4'h2, rd); check("data2", rd, 32'h0000_0005);
    apb_read(4'h1, rd); check("status_empty", rd, 32'h0001_0000);
    check("irq_cleared", 32'(irq_out), 32'd0);

    // Overflow: 17 pushes into 16 entries
    for (int i = 1; i <= 17; i++) push(16'(i));
    apb_read(4'h1, rd); check("status_full_ovf", rd, 32'h0006_0010);
    check("irq_full", 32'(irq_out), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      apb_read(4'h2, rd); check($sformatf("ovf_data%0d", i), rd, 32'(i));
    end
    apb_read(4'h1, rd); check("status_empty_ovf", rd, 32'h0005_0000);
    apb_read(4'h3, rd);
`ifdef DFE_FIFO_OVF_CNT_EN
    check("ovfcnt", rd, 32'd1);
`else
    check("ovfcnt_absent", rd, 32'd0);
`endif
    apb_write(4'h1, 32'h0004_0000);
    apb_read(4'h1, rd); check("ovf_cleared", rd, 32'h0001_0000);
    check("irq_after_ovf_clear", 32'(irq_out), 32'd0);

    // Full FIFO, push coinciding with a DATA access phase
    for (int i = 1; i <= 16; i++) push(16'h0100 + 16'(i));
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 4'h2; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1; dfe_data_in = 16'h01FF; dfe_valid_in = 1'b1;
    #1 check("full_pushpop_data", PRDATA, 32'h0000_0101);
    step();
    PSEL = 1'b0; PENABLE = 1'b0; dfe_valid_in = 1'b0;
    apb_read(4'h1, rd); check("full_pushpop_status", rd, 32'h0002_0010);
    for (int i = 2; i <= 16; i++) begin
      apb_read(4'h2, rd); check($sformatf("pp_data%0d", i), rd, 32'h0100 + 32'(i));
    end
    apb_read(4'h2, rd); check("pp_last_is_new", rd, 32'h0000_01FF);

    // Underflow
    apb_read(4'h2, rd); check("unf_data_zero", rd, 32'd0);
    apb_read(4'h1, rd); check("status_unf", rd, 32'h0009_0000);
    apb_write(4'h1, 32'h0008_0000);
    apb_read(4'h1, rd); check("unf_cleared", rd, 32'h0001_0000);

    // Flush with a same-cycle push
    for (int i = 0; i < 5; i++) push(16'h0A00 + 16'(i));
    apb_read(4'h1, rd); check("five_queued", rd, 32'h0000_0005);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 32'h03; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1; dfe_data_in = 16'h0BAD; dfe_valid_in = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; dfe_valid_in = 1'b0;
    apb_read(4'h1, rd); check("flush_status", rd, 32'h0001_0000);
    apb_read(4'h0, rd); check("ctrl_flush_reads0", rd, 32'h01);
    push(16'hABCD);
    apb_read(4'h2, rd); check("post_flush_data", rd, 32'hFFFF_ABCD);

    // Flush keeps a pending OVF
    for (int i = 0; i < 17; i++) push(16'(i));
    apb_write(4'h0, 32'h03);
    apb_read(4'h1, rd); check("flush_keeps_ovf", rd, 32'h0005_0000);
    apb_write(4'h1, 32'h0004_0000);

    // EN=0 blocks pushes, pops still allowed
    push(16'h1234);
    apb_write(4'h0, 32'h00);
    push(16'h5678);
    apb_read(4'h2, rd); check("en0_pop", rd, 32'h0000_1234);
    apb_read(4'h1, rd); check("en0_no_push", rd, 32'h0001_0000);

    // Unmapped accesses
    apb_write(4'h5, 32'hFFFF_FFFF);
    apb_read(4'h0, rd); check("unmapped_write_ignored", rd, 32'h0);
    apb_read(4'h7, rd); check("unmapped_read", rd, 32'h0);

    // Reset mid-operation discards samples
    apb_write(4'h0, 32'h11);
    push(16'h0001); push(16'h0002);
    PRESETn = 1'b0;
    #3 check("async_irq_clear", 32'(irq_out), 32'd0);
    step();
    PRESETn = 1'b1;
    step();
    apb_read(4'h1, rd); check("status_after_mid_reset", rd, 32'h0001_0000);
    apb_read(4'h0, rd); check("ctrl_after_mid_reset", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
